// File: rtl/mult_div_unit.sv
// HI/LO multiply-divide unit: multi-cycle MULT/MULTU/DIV/DIVU with a fixed busy window,
// single-cycle MTHI/MTLO, requests ignored while busy.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  localparam int MAXC  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } md_req_t;

  state_t             state;
  md_req_t            req;
  logic [CNT_W-1:0]   cnt;

  logic               sgn;
  logic [63:0]        prod;
  logic [31:0]        ua, ub, uq, ur, quo, rem;
  logic [31:0]        res_hi, res_lo;
  logic               res_wr;

  assign stall_req = busy | (start & ~md_op[2]);

  // Results are formed from the operands captured at issue; the 64-bit product of
  // sign- or zero-extended operands is exact in its low 64 bits for both flavours.
  // Signed divide works on magnitudes so 0x80000000 / -1 cannot overflow.
  always_comb begin
    sgn    = ~req.op[0];
    prod   = {{32{sgn & req.a[31]}}, req.a} * {{32{sgn & req.b[31]}}, req.b};
    ua     = (sgn & req.a[31]) ? -req.a : req.a;
    ub     = (sgn & req.b[31]) ? -req.b : req.b;
    uq     = ua / ub;
    ur     = ua % ub;
    quo    = (sgn & (req.a[31] ^ req.b[31])) ? -uq : uq;
    rem    = (sgn & req.a[31]) ? -ur : ur;
    res_hi = req.op[1] ? rem : prod[63:32];
    res_lo = req.op[1] ? quo : prod[31:0];
    res_wr = ~req.op[1] | (req.b != 32'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      cnt   <= '0;
      req   <= '0;
      HI    <= '0;
      LO    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (md_op)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                req   <= '{op: md_op, a: A, b: B};
                cnt   <= md_op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                busy  <= 1'b1;
                state <= RUN;
              end
              3'd4:    HI <= A;
              3'd5:    LO <= A;
              default: ;
            endcase
          end
        end
        RUN: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            busy  <= 1'b0;
            state <= IDLE;
            if (res_wr) begin
              HI <= res_hi;
              LO <= res_lo;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, meaning busy duration in cycles for MULT/MULTU.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, meaning busy duration in cycles for DIV/DIVU.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to issue md_op this cycle.
REQ-006 SHALL have port md_op  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved.
REQ-007 SHALL have port A  input  32  operand rs (dividend/multiplicand, or MTHI/MTLO data).
REQ-008 SHALL have port B  input  32  operand rt (divisor/multiplier).
REQ-009 SHALL have port busy  output  1  registered; high while a multi-cycle op is in flight.
REQ-010 SHALL have port stall_req  output  1  combinational: busy | (start & md_op<=3); drives the D-stage stall for md/mf/mt instructions.
REQ-011 SHALL have port HI  output  32  architectural HI register, registered.
REQ-012 SHALL have port LO  output  32  architectural LO register, registered; HI/LO feed the E-stage result mux toward the GRF write port.

Function
REQ-013 SHALL implement a two-state FSM: IDLE, RUN.
REQ-014 In IDLE, start with md_op 0..3 at edge k SHALL latch A, B, md_op and load a down-counter with MULT_CYCLES (ops 0,1) or DIV_CYCLES (ops 2,3), go to RUN.
REQ-015 busy SHALL be high from after edge k through edge k+N, N being the loaded cycle count, i.e. exactly N cycles.
REQ-016 In RUN the counter SHALL decrement each edge; at the edge where it reaches zero, HI/LO SHALL be written and FSM SHALL return to IDLE with busy low.
REQ-017 Results SHALL be computed from operands latched at issue; changes on A/B/md_op during RUN SHALL have no effect.
REQ-018 start asserted while busy SHALL be ignored (no latch, no HI/LO write, counter undisturbed).
REQ-019 MULT SHALL produce signed 64-bit A*B; MULTU unsigned; HI = bits 63:32, LO = bits 31:0.
REQ-020 DIV SHALL produce signed quotient truncated toward zero into LO, remainder (sign of dividend) into HI; DIVU unsigned.
REQ-021 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000.
REQ-022 Division with B=0 SHALL still hold busy DIV_CYCLES cycles and SHALL leave HI/LO unchanged at completion.
REQ-023 MTHI (op 4) with start in IDLE SHALL write HI<=A at the same edge, no busy, LO unchanged; MTLO (op 5) likewise for LO.
REQ-024 MTHI/MTLO with start while busy SHALL be ignored.
REQ-025 Reserved ops 6/7 with start SHALL be no-ops in any state.
REQ-026 The upstream controller guarantees at most one start per issued instruction; the block SHALL NOT queue requests.

Reset
REQ-027 reset high at an edge SHALL force HI=0, LO=0, busy=0, counter=0, FSM=IDLE, overriding start.
REQ-028 reset during RUN SHALL abort the operation; no HI/LO write of the aborted result ever occurs.
REQ-029 First start accepted SHALL be at the first edge with reset low.

Verification
REQ-030 Reset then MULT A=0xFFFFFFFE B=3 -> busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-031 DIV A=0xFFFFFFF9 (-7) B=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 -> LO=3, HI=1.
REQ-032 MTHI A=0x12345678 then MTLO A=0x9ABCDEF0 on consecutive cycles -> HI/LO updated on each respective edge, busy stays 0.
REQ-033 DIV B=0 after MTHI 0x11/MTLO 0x22 -> busy 10 cycles, HI=0x11, LO=0x22 afterward; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-034 MULT issued, then start MTLO and new MULT at cycles 2 and 3 of busy with changed A/B -> both ignored, result matches original operands, stall_req high throughout busy.
REQ-035 DIV issued, reset asserted at busy cycle 4 -> next cycle busy=0, HI=LO=0; no later HI/LO change.
